// File: rtl/twowire_pkg.sv
// Shared two-wire debug transport definitions: command codes, write-command set,
// connect signature default and serial FSM state encodings.
package twowire_pkg;

    localparam int unsigned CMD_W  = 4;
    localparam int unsigned SIG_W  = 16;
    localparam int unsigned ADDR_W = 4;

    localparam logic [SIG_W-1:0] CONNECT_SEQ_DEFAULT = 16'hd0c2;

    typedef enum logic [CMD_W-1:0] {
        CMD_DISCONNECT = 4'h0,
        CMD_RD_DATA    = 4'h1,
        CMD_RD_STATUS  = 4'h2,
        CMD_RD_IDCODE  = 4'h3,
        CMD_WR_ADDR    = 4'h8,
        CMD_WR_DATA    = 4'h9,
        CMD_WR_CTRL    = 4'ha
    } twd_cmd_e;

    typedef enum logic [2:0] {
        S_DISC     = 3'd0,
        S_IDLE     = 3'd1,
        S_CMD      = 3'd2,
        S_PARITY   = 3'd3,
        S_DISPATCH = 3'd4,
        S_RDATA    = 3'd5,
        S_TURN     = 3'd6,
        S_WDATA    = 3'd7
    } twd_state_e;

    // Commands whose payload flows host -> target; everything else (incl. unknown) reads.
    function automatic logic is_write_cmd(input logic [CMD_W-1:0] c);
        return (c == CMD_WR_ADDR) || (c == CMD_WR_DATA) || (c == CMD_WR_CTRL);
    endfunction

endpackage

// File: rtl/twowire_connect_detect.sv
// Connect-signature matcher: shifts di LSB-first while enabled and pulses match_o.
// Optional TWD_MULTIDROP_EN appends a 4-bit LSB-first address that must equal addr_i.
module twowire_connect_detect
    import twowire_pkg::*;
#(
    parameter logic [SIG_W-1:0] SEQ = CONNECT_SEQ_DEFAULT
) (
    input  logic              dck,
    input  logic              drst_n,
    input  logic              di_i,
    input  logic              en_i,
    input  logic [ADDR_W-1:0] addr_i,
    output logic              match_o
);

    localparam int unsigned ACNT_W = $clog2(ADDR_W);

    logic [SIG_W-1:0] hist_q, hist_d;
    logic             match_q, match_d;

`ifdef TWD_MULTIDROP_EN
    logic              addr_phase_q, addr_phase_d;
    logic [ADDR_W-1:0] addr_sh_q, addr_sh_d;
    logic [ACNT_W-1:0] acnt_q, acnt_d;

    // Signature phase, then address phase; any address miss restarts from a clean history.
    always_comb begin
        hist_d       = hist_q;
        match_d      = 1'b0;
        addr_phase_d = addr_phase_q;
        addr_sh_d    = addr_sh_q;
        acnt_d       = acnt_q;
        if (!en_i) begin
            hist_d       = '0;
            addr_phase_d = 1'b0;
            acnt_d       = '0;
        end else if (!addr_phase_q) begin
            hist_d = {di_i, hist_q[SIG_W-1:1]};
            if (hist_d == SEQ) begin
                hist_d       = '0;
                addr_phase_d = 1'b1;
                acnt_d       = '0;
            end
        end else begin
            addr_sh_d = {di_i, addr_sh_q[ADDR_W-1:1]};
            if (acnt_q == ACNT_W'(ADDR_W - 1)) begin
                addr_phase_d = 1'b0;
                match_d      = (addr_sh_d == addr_i);
            end else begin
                acnt_d = acnt_q + ACNT_W'(1);
            end
        end
    end

    always_ff @(posedge dck or negedge drst_n) begin
        if (!drst_n) begin
            addr_phase_q <= 1'b0;
            addr_sh_q    <= '0;
            acnt_q       <= '0;
        end else begin
            addr_phase_q <= addr_phase_d;
            addr_sh_q    <= addr_sh_d;
            acnt_q       <= acnt_d;
        end
    end
`else
    logic unused_addr;
    assign unused_addr = ^addr_i;

    // History is cleared on a hit so a single signature yields a single pulse.
    always_comb begin
        hist_d  = hist_q;
        match_d = 1'b0;
        if (!en_i) begin
            hist_d = '0;
        end else begin
            hist_d = {di_i, hist_q[SIG_W-1:1]};
            if (hist_d == SEQ) begin
                hist_d  = '0;
                match_d = 1'b1;
            end
        end
    end
`endif

    always_ff @(posedge dck or negedge drst_n) begin
        if (!drst_n) begin
            hist_q  <= '0;
            match_q <= 1'b0;
        end else begin
            hist_q  <= hist_d;
            match_q <= match_d;
        end
    end

    assign match_o = match_q;

endmodule

// File: rtl/twowire_dtm_serial.sv
// Two-wire debug transport serial front end: connect, command/parity capture, dispatch,
// read/write payload phases. Build option TWD_MULTIDROP_EN adds a multidrop address stage.
module twowire_dtm_serial
    import twowire_pkg::*;
#(
    parameter int unsigned      W_CMD       = 4,
    parameter logic [SIG_W-1:0] CONNECT_SEQ = CONNECT_SEQ_DEFAULT
) (
    input  logic             dck,
    input  logic             drst_n,
    input  logic             di_i,
    output logic             do_o,
    output logic             doe_o,
    output logic             connected_o,
    input  logic             disconnect_now_i,
    input  logic [3:0]       mdropaddr_i,
    output logic [W_CMD-1:0] cmd_o,
    output logic             cmd_vld_o,
    input  logic             cmd_payload_end_i,
    output logic             serial_parity_err_o,
    output logic             serial_wdata_o,
    output logic             serial_wdata_vld_o,
    input  logic             serial_rdata_i,
    output logic             serial_rdata_rdy_o
);

    localparam int unsigned W_CNT = (W_CMD > 1) ? $clog2(W_CMD) : 1;

    twd_state_e       state_q, state_d;
    logic [W_CNT-1:0] bcnt_q, bcnt_d;
    logic [W_CMD-1:0] cmd_q, cmd_d;
    logic             doe_q, doe_d;
    logic             conn_q, conn_d;
    logic             perr_q, perr_d;
    logic             conn_match;

    twowire_connect_detect #(
        .SEQ (CONNECT_SEQ)
    ) u_connect_detect (
        .dck     (dck),
        .drst_n  (drst_n),
        .di_i    (di_i),
        .en_i    (state_q == S_DISC),
        .addr_i  (mdropaddr_i),
        .match_o (conn_match)
    );

    // Next-state logic; a forced disconnect wins over every other transition.
    always_comb begin
        state_d = state_q;
        bcnt_d  = bcnt_q;
        cmd_d   = cmd_q;
        perr_d  = 1'b0;
        case (state_q)
            S_DISC: begin
                if (conn_match) state_d = S_IDLE;
            end
            S_IDLE: begin
                if (!di_i) begin
                    state_d = S_CMD;
                    bcnt_d  = W_CNT'(W_CMD - 1);
                end
            end
            S_CMD: begin
                cmd_d = W_CMD'({cmd_q, di_i});
                if (bcnt_q == '0) state_d = S_PARITY;
                else              bcnt_d  = bcnt_q - W_CNT'(1);
            end
            S_PARITY: begin
                if (di_i == ~^cmd_q) begin
                    state_d = S_DISPATCH;
                end else begin
                    state_d = S_IDLE;
                    perr_d  = 1'b1;
                end
            end
            S_DISPATCH: begin
                state_d = is_write_cmd(CMD_W'(cmd_q)) ? S_WDATA : S_RDATA;
            end
            S_RDATA: begin
                if (cmd_payload_end_i) state_d = S_TURN;
            end
            S_TURN: begin
                state_d = S_IDLE;
            end
            S_WDATA: begin
                if (cmd_payload_end_i) state_d = S_IDLE;
            end
            default: begin
                state_d = S_DISC;
            end
        endcase
        if (disconnect_now_i) begin
            state_d = S_DISC;
            perr_d  = 1'b0;
        end
        doe_d  = (state_d == S_RDATA);
        conn_d = (state_d != S_DISC);
    end

    always_ff @(posedge dck or negedge drst_n) begin
        if (!drst_n) begin
            state_q <= S_DISC;
            bcnt_q  <= '0;
            cmd_q   <= '0;
            doe_q   <= 1'b0;
            conn_q  <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
            cmd_q   <= cmd_d;
            doe_q   <= doe_d;
            conn_q  <= conn_d;
            perr_q  <= perr_d;
        end
    end

    // Strobes and payload data decode directly from the current state.
    assign cmd_vld_o          = (state_q == S_DISPATCH);
    assign serial_rdata_rdy_o = (state_q == S_RDATA);
    assign do_o               = (state_q == S_RDATA) & serial_rdata_i;
    assign serial_wdata_vld_o = (state_q == S_WDATA);
    assign serial_wdata_o     = (state_q == S_WDATA) & di_i;

    assign doe_o               = doe_q;
    assign connected_o         = conn_q;
    assign cmd_o               = cmd_q;
    assign serial_parity_err_o = perr_q;

endmodule
